// File: rtl/state3_pkg.sv
// Shared types and constants for the three-phase controller stimulus driver.
package state3_pkg;

  localparam int HOLD_W = 8;
  localparam int TO_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_STOP  = 3'd2,
    S_ARM   = 3'd3,
    S_REL   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_K2_TO = 2'd1;
  localparam logic [1:0] ERR_K1_TO = 2'd2;
  localparam logic [1:0] ERR_SPUR  = 2'd3;

endpackage

// File: rtl/state3_drv_timer.sv
// Loadable up-counter shared by the hold phases and the strobe-wait phases.
module state3_drv_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         hit
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(1);
  end

  assign hit = (cnt == limit - W'(1));

endmodule

// File: rtl/state3_drv.sv
// Drives the controller's A line through START/STOP/CLEAR and checks K2/K1.
// Define STATE3_DRV_TIMEOUT_EN to bound the K2/K1 waits by TO_CYC cycles.
module state3_drv
  import state3_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned TO_CYC   = 64
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        req_i,
  input  logic        abort_i,
  input  logic        k1_i,
  input  logic        k2_i,
  output logic        a_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [15:0] cyc_cnt_o
);

  state_t            state, nxt;
  logic              hit, clr, en, spur;
  logic              done_n, err_n;
  logic [1:0]        code_n;
  logic [TO_W-1:0]   limit;

  assign limit = (state == S_START || state == S_STOP) ? TO_W'(HOLD_CYC) : TO_W'(TO_CYC);
  // Every phase change restarts the shared timer from zero.
  assign clr   = (nxt != state);
  assign en    = (state != S_IDLE);

  state3_drv_timer #(.W(TO_W)) u_timer (
    .clk   (clk_i),
    .rst   (rst),
    .clr   (clr),
    .en    (en),
    .limit (limit),
    .hit   (hit)
  );

  assign spur = (k1_i && state != S_REL) || (k2_i && state != S_ARM);

  always_comb begin
    nxt    = state;
    done_n = 1'b0;
    err_n  = 1'b0;
    code_n = err_code_o;
    if (state != S_IDLE && abort_i) begin
      nxt = S_IDLE;
    end else if (spur) begin
      nxt    = S_IDLE;
      err_n  = 1'b1;
      code_n = ERR_SPUR;
    end else begin
      case (state)
        S_IDLE:  if (req_i) nxt = S_START;
        S_START: if (hit)   nxt = S_STOP;
        S_STOP:  if (hit)   nxt = S_ARM;
        S_ARM: begin
          if (k2_i) nxt = S_REL;
`ifdef STATE3_DRV_TIMEOUT_EN
          else if (hit) begin
            nxt    = S_IDLE;
            err_n  = 1'b1;
            code_n = ERR_K2_TO;
          end
`endif
        end
        S_REL: begin
          if (k1_i) begin
            nxt    = S_IDLE;
            done_n = 1'b1;
          end
`ifdef STATE3_DRV_TIMEOUT_EN
          else if (hit) begin
            nxt    = S_IDLE;
            err_n  = 1'b1;
            code_n = ERR_K1_TO;
          end
`endif
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      a_o        <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= ERR_NONE;
      cyc_cnt_o  <= '0;
    end else begin
      state      <= nxt;
      a_o        <= (nxt == S_START) || (nxt == S_ARM);
      done_o     <= done_n;
      err_o      <= err_n;
      err_code_o <= code_n;
      if (done_n) cyc_cnt_o <= cyc_cnt_o + 16'd1;
    end
  end

  assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_state3_drv.sv
// Directed bench for state3_drv with a behavioural controller answering on A.
module tb_state3_drv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        abort = 1'b0;
  logic        k1, k2;
  logic        a, busy, done, err;
  logic [1:0]  code;
  logic [15:0] cnt;

  int total = 0;
  int bad   = 0;

  // controller model: K2 on first cycle of second A pulse, K1 on the fall after it
  logic ctl_en = 1'b1;
  logic frc_k1 = 1'b0;
  logic frc_k2 = 1'b0;
  logic a_q;
  int   nrise;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= 1'b0;
      nrise <= 0;
    end else begin
      a_q <= a;
      if (!busy)         nrise <= 0;
      else if (a && !a_q) nrise <= nrise + 1;
    end
  end

  assign k2 = (ctl_en && a && !a_q && nrise == 1) || frc_k2;
  assign k1 = (ctl_en && !a && a_q && nrise == 2) || frc_k1;

  state3_drv #(.HOLD_CYC(2), .TO_CYC(4)) dut (
    .clk_i      (clk),
    .rst        (rst),
    .req_i      (req),
    .abort_i    (abort),
    .k1_i       (k1),
    .k2_i       (k2),
    .a_o        (a),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .err_code_o (code),
    .cyc_cnt_o  (cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // pulse req and wait for done; n is the cycle of done relative to the sampling edge
  task automatic do_cycle(output int n);
    req = 1'b1;
    tick;
    req = 1'b0;
    n = 1;
    while (!done && !err && n < 40) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    total++;
    if ({a, busy, done, err, code, cnt} !== 22'd0) begin
      bad++;
      $display("FAIL reset: got a=%b busy=%b done=%b err=%b code=%0d cnt=%0d, want all 0", a, busy, done, err, code, cnt);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_normal;
    logic [6:1] pat;
    pat = 6'b010011; // a_o for cycles 1..6: 1,1,0,0,1,0
    req = 1'b1;
    tick;
    req = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      total++;
      if (a !== pat[i] || done !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL normal_a c%0d: got a=%b done=%b busy=%b, want a=%b done=0 busy=1", i, a, done, busy, pat[i]);
      end
      tick;
    end
    total++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || cnt !== 16'd1 || code !== 2'd0 || a !== 1'b0) begin
      bad++;
      $display("FAIL normal_done: got done=%b err=%b busy=%b cnt=%0d code=%0d a=%b, want 1 0 0 1 0 0", done, err, busy, cnt, code, a);
    end
    tick;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL normal_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    req = 1'b1;
    tick;
    n = 1;
    while (!done && n < 40) begin tick; n++; end
    total++;
    if (n !== 7 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first: done at %0d busy=%b, want 7 busy=0", n, busy);
    end
    // req still high in the done cycle: taken immediately
    tick;
    req = 1'b0;
    n = 1;
    while (!done && n < 40) begin tick; n++; end
    total++;
    if (n !== 7 || cnt !== 16'd3) begin
      bad++;
      $display("FAIL b2b_second: done at %0d cnt=%0d, want 7 cnt=3", n, cnt);
    end
    tick;
  endtask

  task automatic test_spurious;
    req = 1'b1;
    tick;
    req = 1'b0;
    frc_k1 = 1'b1;
    tick;
    frc_k1 = 1'b0;
    total++;
    if (err !== 1'b1 || code !== 2'd3 || done !== 1'b0 || busy !== 1'b0 || a !== 1'b0) begin
      bad++;
      $display("FAIL spur_start: got err=%b code=%0d done=%b busy=%b a=%b, want 1 3 0 0 0", err, code, done, busy, a);
    end
    tick;
    total++;
    if (err !== 1'b0 || code !== 2'd3 || cnt !== 16'd3) begin
      bad++;
      $display("FAIL spur_hold: got err=%b code=%0d cnt=%0d, want 0 3 3", err, code, cnt);
    end
  endtask

  task automatic test_spur_idle;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    frc_k2 = 1'b1;
    tick;
    frc_k2 = 1'b0;
    total++;
    if (err !== 1'b1 || code !== 2'd3 || busy !== 1'b0) begin
      bad++;
      $display("FAIL spur_idle: got err=%b code=%0d busy=%b, want 1 3 0", err, code, busy);
    end
    tick;
  endtask

  task automatic test_abort;
    logic [15:0] c0;
    c0 = cnt;
    req = 1'b1;
    tick;
    req = 1'b0;
    tick;
    tick;
    total++;
    if (a !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre: in P_STOP got a=%b busy=%b, want 0 1", a, busy);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    total++;
    if (a !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cnt !== c0) begin
      bad++;
      $display("FAIL abort: got a=%b busy=%b done=%b err=%b cnt=%0d, want 0 0 0 0 %0d", a, busy, done, err, cnt, c0);
    end
    tick;
  endtask

  task automatic test_timeout;
    ctl_en = 1'b0;
    req = 1'b1;
    tick;
    req = 1'b0;
    for (int i = 1; i < 5; i++) tick;
    total++;
    if (a !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL to_arm: first P_ARM cycle a=%b busy=%b, want 1 1", a, busy);
    end
`ifdef STATE3_DRV_TIMEOUT_EN
    for (int i = 0; i < 3; i++) tick;
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL to_early: fourth P_ARM cycle err=%b busy=%b, want 0 1", err, busy);
    end
    tick;
    total++;
    if (err !== 1'b1 || code !== 2'd1 || a !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL to_k2: got err=%b code=%0d a=%b busy=%b done=%b, want 1 1 0 0 0", err, code, a, busy, done);
    end
`else
    for (int i = 0; i < 20; i++) tick;
    total++;
    if (err !== 1'b0 || busy !== 1'b1 || a !== 1'b1) begin
      bad++;
      $display("FAIL wait_k2: got err=%b busy=%b a=%b, want 0 1 1", err, busy, a);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || a !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL wait_abort: got busy=%b a=%b err=%b, want 0 0 0", busy, a, err);
    end
`endif
    ctl_en = 1'b1;
    tick;
  endtask

  task automatic test_rst_mid;
    int n;
    req = 1'b1;
    tick;
    req = 1'b0;
    for (int i = 1; i < 5; i++) tick;
    rst = 1'b1;
    #1;
    total++;
    if ({a, busy, done, err, code, cnt} !== 22'd0) begin
      bad++;
      $display("FAIL rst_mid: got a=%b busy=%b done=%b err=%b code=%0d cnt=%0d, want all 0", a, busy, done, err, code, cnt);
    end
    tick;
    rst = 1'b0;
    tick;
    do_cycle(n);
    total++;
    if (n !== 7 || done !== 1'b1 || cnt !== 16'd1 || code !== 2'd0) begin
      bad++;
      $display("FAIL rst_recover: done at %0d done=%b cnt=%0d code=%0d, want 7 1 1 0", n, done, cnt, code);
    end
    tick;
  endtask

  task automatic test_wrap;
    int n;
    force dut.cyc_cnt_o = 16'hFFFF;
    tick;
    release dut.cyc_cnt_o;
    tick;
    total++;
    if (cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_preload: cnt=%h, want ffff", cnt);
    end
    do_cycle(n);
    total++;
    if (n !== 7 || cnt !== 16'h0000) begin
      bad++;
      $display("FAIL wrap: done at %0d cnt=%h, want 7 0000", n, cnt);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_normal;
    test_back_to_back;
    test_spurious;
    test_spur_idle;
    test_abort;
    test_timeout;
    test_rst_mid;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
